parity_checker: RTL and testbench
=================================

PARITY_CHECKER -- requirements
Module: parity_checker

Interface
REQ-001 SHALL have parameter ODD, default 0; 0 = even-parity convention (expected bit = XOR of data), 1 = odd (expected bit = ~XOR of data).
REQ-002 SHALL have port Clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port Reset  input  1  reset, asynchronous and active-low; 0 clears all state immediately.
REQ-004 SHALL have port InValid  input  1  upstream byte present.
REQ-005 SHALL have port InData  input  8  upstream byte.
REQ-006 SHALL have port InPar  input  1  received parity bit accompanying InData.
REQ-007 SHALL have port InLast  input  1  byte is the last of its frame.
REQ-008 SHALL have port InReady  output  1  block accepts the byte this cycle.
REQ-009 SHALL have port OutValid  output  1  checked byte present downstream.
REQ-010 SHALL have port OutData  output  8  checked byte.
REQ-011 SHALL have port OutErr  output  1  computed parity of OutData mismatched its received bit.
REQ-012 SHALL have port OutReady  input  1  downstream accepts the byte this cycle.
REQ-013 SHALL have port FrameDone  output  1  one-cycle pulse at end of frame.
REQ-014 SHALL have port FrameErr  output  1  at least one byte of the finished frame had OutErr; valid only with FrameDone.
REQ-015 SHALL have port ErrCount  output  8  running count of bad bytes since reset.

Function
REQ-016 SHALL transfer an input byte only when InValid and InReady are both 1; SHALL transfer an output byte only when OutValid and OutReady are both 1.
REQ-017 SHALL hold a 2-entry FIFO (skid buffer) between input and output; InReady = FIFO not full and state != REPORT.
REQ-018 SHALL compute parity of each accepted byte at acceptance and store {data, err, last} in the FIFO entry; OutErr = (computed expected bit != InPar).
REQ-019 SHALL present an accepted byte on OutData no earlier than the next cycle (latency 1 when FIFO empty and OutReady=1); OutData/OutErr SHALL stay stable while OutValid=1 and OutReady=0.
REQ-020 SHALL support accept and drain in the same cycle at full throughput (one byte/cycle), including while FIFO holds one entry.
REQ-021 SHALL run FSM IDLE -> ACTIVE on first byte accepted; ACTIVE -> REPORT when the entry with last=1 is drained downstream; REPORT -> IDLE after exactly one cycle.
REQ-022 SHALL accept a byte with InLast=1 in IDLE as a one-byte frame (IDLE -> ACTIVE, then REPORT on drain).
REQ-023 SHALL assert FrameDone only in REPORT; FrameErr = OR of OutErr of all bytes drained in that frame; frame error accumulator cleared on entering IDLE.
REQ-024 SHALL deassert InReady during REPORT; bytes offered then are held by upstream, not lost.
REQ-025 SHALL increment ErrCount by 1 per drained byte with OutErr=1, saturating at 255 (no wrap).
REQ-026 SHALL treat FIFO full + OutReady=0 as stall: InReady=0, no state change.

Reset
REQ-027 SHALL on Reset=0: FIFO empty, FSM IDLE, InReady=0 while Reset=0 then 1 from first cycle after release, OutValid=0, OutData=0, OutErr=0, FrameDone=0, FrameErr=0, ErrCount=0.
REQ-028 SHALL discard any in-flight frame on reset mid-frame; no FrameDone is issued for it.

Configuration
REQ-029 SHALL compile ErrCount logic only when macro PARITY_CHECKER_ERRCNT_EN is defined; without it ErrCount SHALL be tied to 8'h00 and all other behaviour is unchanged.

Verification
REQ-030 SHALL cover: ODD=0, bytes 8'h03/InPar=0, 8'h07/InPar=1, 8'h01/InPar=0 (last), OutReady=1 -> OutErr 0,0,1; FrameDone one cycle after third drain with FrameErr=1; ErrCount=1.
REQ-031 SHALL cover: ODD=1, single byte 8'h00/InPar=1/InLast=1 -> OutErr=0, FrameDone=1, FrameErr=0.
REQ-032 SHALL cover: continuous InValid with OutReady held 0 for 5 cycles -> exactly 2 bytes accepted, InReady=0 thereafter, no byte lost or duplicated after OutReady=1.
REQ-033 SHALL cover: 300 consecutive bad-parity bytes -> ErrCount saturates at 255 (macro defined); reads 0 throughout with macro undefined.
REQ-034 SHALL cover: Reset=0 asserted mid-frame with FIFO full -> outputs zero asynchronously, no FrameDone; next frame checks correctly.
REQ-035 SHALL cover: InValid=1 during REPORT cycle -> InReady=0 that cycle, byte accepted the following cycle as first byte of new frame.

Source files
------------

// File: rtl/parity_checker.sv
// rtl/parity_checker.sv - per-byte parity check through a 2-entry skid FIFO with frame error reporting
// ErrCount logic is built only when PARITY_CHECKER_ERRCNT_EN is defined; otherwise it reads 8'h00.
module parity_checker #(
  parameter int ODD = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       InValid,
  input  logic [7:0] InData,
  input  logic       InPar,
  input  logic       InLast,
  output logic       InReady,
  output logic       OutValid,
  output logic [7:0] OutData,
  output logic       OutErr,
  input  logic       OutReady,
  output logic       FrameDone,
  output logic       FrameErr,
  output logic [7:0] ErrCount
);

  localparam logic ODD_BIT = (ODD != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_REPORT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0][7:0] data_q;
  logic [1:0]      err_q;
  logic [1:0]      last_q;
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      count_q, count_d;
  logic            rdy_q;
  logic            frame_err_q, frame_err_d;

  logic            accept;
  logic            drain;
  logic            in_err;
  logic            head_err;
  logic            head_last;

  assign accept    = InValid & InReady;
  assign drain     = OutValid & OutReady;
  assign in_err    = ((^InData) ^ ODD_BIT) != InPar;
  assign head_err  = err_q[rd_ptr_q];
  assign head_last = last_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({accept, drain})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // rdy_q holds InReady low until the first clock edge after reset release.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      data_q   <= '0;
      err_q    <= '0;
      last_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (accept) begin
        data_q[wr_ptr_q] <= InData;
        err_q[wr_ptr_q]  <= in_err;
        last_q[wr_ptr_q] <= InLast;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (drain) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Bytes of the next frame may already sit in the FIFO when REPORT ends, so IDLE also drains.
  always_comb begin
    state_d     = state_q;
    frame_err_d = frame_err_q;
    case (state_q)
      S_IDLE: begin
        frame_err_d = frame_err_q | (drain & head_err);
        if (drain && head_last) begin
          state_d = S_REPORT;
        end else if (accept || (count_q != 2'd0)) begin
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        frame_err_d = frame_err_q | (drain & head_err);
        if (drain && head_last) begin
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        frame_err_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        frame_err_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_comb begin
    InReady   = rdy_q && (count_q != 2'd2) && (state_q != S_REPORT);
    OutValid  = (count_q != 2'd0) && (state_q != S_REPORT);
    OutData   = OutValid ? data_q[rd_ptr_q] : 8'h00;
    OutErr    = OutValid ? head_err : 1'b0;
    FrameDone = (state_q == S_REPORT);
    FrameErr  = (state_q == S_REPORT) && frame_err_q;
  end

`ifdef PARITY_CHECKER_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      err_cnt_q <= 8'h00;
    end else if (drain && head_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign ErrCount = err_cnt_q;
`else
  assign ErrCount = 8'h00;
`endif

endmodule

// File: tb/tb_parity_checker.sv
// tb/tb_parity_checker.sv - directed self-checking bench for parity_checker (ODD=0 and ODD=1 instances)
module tb_parity_checker;

  logic       clk;
  logic       rst_n;

  logic       v0, p0, l0, or0;
  logic [7:0] d0;
  logic       rdy0, ov0, oe0, fd0, fe0;
  logic [7:0] od0, ec0;

  logic       v1, p1, l1, or1;
  logic [7:0] d1;
  logic       rdy1, ov1, oe1, fd1, fe1;
  logic [7:0] od1, ec1;

  int checks   = 0;
  int failures = 0;
  int exp_errs = 0;

  parity_checker #(.ODD(0)) dut0 (
    .Clk(clk), .Reset(rst_n),
    .InValid(v0), .InData(d0), .InPar(p0), .InLast(l0), .InReady(rdy0),
    .OutValid(ov0), .OutData(od0), .OutErr(oe0), .OutReady(or0),
    .FrameDone(fd0), .FrameErr(fe0), .ErrCount(ec0)
  );

  parity_checker #(.ODD(1)) dut1 (
    .Clk(clk), .Reset(rst_n),
    .InValid(v1), .InData(d1), .InPar(p1), .InLast(l1), .InReady(rdy1),
    .OutValid(ov1), .OutData(od1), .OutErr(oe1), .OutReady(or1),
    .FrameDone(fd1), .FrameErr(fe1), .ErrCount(ec1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef PARITY_CHECKER_ERRCNT_EN
    return (exp_errs > 255) ? 32'd255 : 32'(exp_errs);
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive0(input logic v, input logic [7:0] d, input logic p, input logic l, input logic o);
    @(negedge clk);
    v0 = v; d0 = d; p0 = p; l0 = l; or0 = o;
    #1;
  endtask

  task automatic drive1(input logic v, input logic [7:0] d, input logic p, input logic l, input logic o);
    @(negedge clk);
    v1 = v; d1 = d; p1 = p; l1 = l; or1 = o;
    #1;
  endtask

  initial begin
    int         sent;
    int         accn;
    int         drained;
    int         bad;
    int         nz;
    logic       done;
    logic       fe_seen;
    logic [7:0] b;
    logic [7:0] got[$];

    rst_n = 1'b0;
    v0 = 0; d0 = 0; p0 = 0; l0 = 0; or0 = 0;
    v1 = 0; d1 = 0; p1 = 0; l1 = 0; or1 = 0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_inready",  32'(rdy0), 32'd0);
    chk("rst_outvalid", 32'(ov0),  32'd0);
    chk("rst_outdata",  32'(od0),  32'd0);
    chk("rst_outerr",   32'(oe0),  32'd0);
    chk("rst_framedone",32'(fd0),  32'd0);
    chk("rst_frameerr", 32'(fe0),  32'd0);
    chk("rst_errcount", 32'(ec0),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("inready_before_first_edge", 32'(rdy0), 32'd0);

    // three-byte frame, ODD=0, full throughput, then a byte offered during REPORT
    drive0(1, 8'h03, 0, 0, 1);
    chk("t1_inready", 32'(rdy0), 32'd1);
    drive0(1, 8'h07, 1, 0, 1);
    chk("t1_b0_valid", 32'(ov0), 32'd1);
    chk("t1_b0_data",  32'(od0), 32'h03);
    chk("t1_b0_err",   32'(oe0), 32'd0);
    drive0(1, 8'h01, 0, 1, 1);
    chk("t1_b1_data",  32'(od0), 32'h07);
    chk("t1_b1_err",   32'(oe0), 32'd0);
    drive0(0, 8'h00, 0, 0, 1);
    chk("t1_b2_data",  32'(od0), 32'h01);
    chk("t1_b2_err",   32'(oe0), 32'd1);
    chk("t1_no_early_done", 32'(fd0), 32'd0);
    exp_errs++;
    drive0(1, 8'hA5, 0, 1, 1);
    chk("t1_framedone", 32'(fd0), 32'd1);
    chk("t1_frameerr",  32'(fe0), 32'd1);
    chk("report_inready", 32'(rdy0), 32'd0);
    chk("t1_errcount",  32'(ec0), exp_cnt());
    drive0(1, 8'hA5, 0, 1, 1);
    chk("post_report_inready", 32'(rdy0), 32'd1);
    chk("post_report_done",    32'(fd0),  32'd0);
    drive0(0, 8'h00, 0, 0, 1);
    chk("t5_data", 32'(od0), 32'hA5);
    chk("t5_err",  32'(oe0), 32'd0);
    drive0(0, 8'h00, 0, 0, 1);
    chk("t5_framedone", 32'(fd0), 32'd1);
    chk("t5_frameerr",  32'(fe0), 32'd0);

    // stall: OutReady low for 5 cycles with continuous InValid
    sent = 0; accn = 0; done = 0; fe_seen = 0;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      b = 8'h10 + 8'(sent);
      drive0(sent < 4, b, ^b, sent == 3, cyc >= 5);
      if (fd0) begin
        done = 1; fe_seen = fe0;
      end
      if (ov0 && or0) got.push_back(od0);
      if (cyc == 4) begin
        chk("stall_inready", 32'(rdy0), 32'd0);
        chk("stall_data_held", 32'(od0), 32'h10);
      end
      if (v0 && rdy0) begin
        sent++;
        if (!or0) accn++;
      end
    end
    chk("stall_accepted", 32'(accn), 32'd2);
    chk("stall_drained",  32'(got.size()), 32'd4);
    for (int i = 0; i < got.size(); i++) begin
      chk($sformatf("stall_order_%0d", i), 32'(got[i]), 32'h10 + 32'(i));
    end
    chk("stall_done",     32'(done), 32'd1);
    chk("stall_frameerr", 32'(fe_seen), 32'd0);

    // 300 bad-parity bytes
    sent = 0; drained = 0; bad = 0; nz = 0; done = 0; fe_seen = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      b = 8'(sent);
      drive0(sent < 300, b, ~(^b), sent == 299, 1);
      if (fd0) begin
        done = 1; fe_seen = fe0;
      end
      if (ec0 !== 8'h00) nz++;
      if (ov0) begin
        drained++;
        if (oe0 !== 1'b1) bad++;
        exp_errs++;
      end
      if (v0 && rdy0) sent++;
    end
    chk("sat_drained",   32'(drained), 32'd300);
    chk("sat_all_bad",   32'(bad), 32'd0);
    chk("sat_done",      32'(done), 32'd1);
    chk("sat_frameerr",  32'(fe_seen), 32'd1);
    chk("sat_errcount",  32'(ec0), exp_cnt());
`ifndef PARITY_CHECKER_ERRCNT_EN
    chk("errcount_zero_throughout", 32'(nz), 32'd0);
`endif

    // asynchronous reset mid-frame with FIFO full
    drive0(1, 8'hF0, 1, 0, 0);
    drive0(1, 8'h0F, 0, 0, 0);
    drive0(1, 8'h33, 0, 0, 0);
    chk("pre_rst_full_inready", 32'(rdy0), 32'd0);
    chk("pre_rst_data", 32'(od0), 32'hF0);
    chk("pre_rst_err",  32'(oe0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_errs = 0;
    chk("arst_outvalid", 32'(ov0),  32'd0);
    chk("arst_outdata",  32'(od0),  32'd0);
    chk("arst_outerr",   32'(oe0),  32'd0);
    chk("arst_inready",  32'(rdy0), 32'd0);
    chk("arst_errcount", 32'(ec0),  32'd0);
    drive0(0, 8'h00, 0, 0, 1);
    chk("arst_no_done_a", 32'(fd0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive0(1, 8'h80, 1, 0, 1);
    chk("arst_no_done_b", 32'(fd0), 32'd0);
    chk("arst_ready_again", 32'(rdy0), 32'd1);
    drive0(1, 8'hFF, 1, 1, 1);
    chk("post_rst_b0_data", 32'(od0), 32'h80);
    chk("post_rst_b0_err",  32'(oe0), 32'd0);
    drive0(0, 8'h00, 0, 0, 1);
    chk("post_rst_b1_data", 32'(od0), 32'hFF);
    chk("post_rst_b1_err",  32'(oe0), 32'd1);
    exp_errs++;
    drive0(0, 8'h00, 0, 0, 1);
    chk("post_rst_framedone", 32'(fd0), 32'd1);
    chk("post_rst_frameerr",  32'(fe0), 32'd1);
    chk("post_rst_errcount",  32'(ec0), exp_cnt());

    // ODD=1 instance: one-byte frames
    drive1(1, 8'h00, 1, 1, 1);
    chk("odd_inready", 32'(rdy1), 32'd1);
    drive1(0, 8'h00, 0, 0, 1);
    chk("odd_b0_valid", 32'(ov1), 32'd1);
    chk("odd_b0_data",  32'(od1), 32'h00);
    chk("odd_b0_err",   32'(oe1), 32'd0);
    drive1(1, 8'h01, 1, 1, 1);
    chk("odd_framedone", 32'(fd1), 32'd1);
    chk("odd_frameerr",  32'(fe1), 32'd0);
    chk("odd_report_inready", 32'(rdy1), 32'd0);
    drive1(1, 8'h01, 1, 1, 1);
    chk("odd_ready_after_report", 32'(rdy1), 32'd1);
    drive1(0, 8'h00, 0, 0, 1);
    chk("odd_b1_data", 32'(od1), 32'h01);
    chk("odd_b1_err",  32'(oe1), 32'd1);
    drive1(0, 8'h00, 0, 0, 1);
    chk("odd_framedone2", 32'(fd1), 32'd1);
    chk("odd_frameerr2",  32'(fe1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
